// File: rtl/skid_pipeline_pkg.sv
// Shared types for the skid pipeline: stage register modes and the full-mode stage FSM states.
package skid_pipeline_pkg;

    typedef enum logic [1:0] {SKID_BYPASS, SKID_FWD, SKID_BWD, SKID_FULL} skid_mode_t;
    typedef enum logic [1:0] {ST_EMPTY, ST_BUSY, ST_FULL} skid_state_t;

    localparam int STAGE_CNT_W = 2;

endpackage

// File: rtl/skid_pipeline_if.sv
// Valid/ready handshake bundle between an upstream producer, the pipeline and a downstream consumer.
interface skid_pipeline_if #(
    parameter int DATA_WIDTH = 32,
    parameter int OCC_W      = 2
);
    import skid_pipeline_pkg::*;

    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [OCC_W-1:0]      occupancy;

    modport master (output in_data, in_valid, out_ready,
                    input  in_ready, out_data, out_valid, occupancy);
    modport slave  (input  in_data, in_valid, out_ready,
                    output in_ready, out_data, out_valid, occupancy);

endinterface

// File: rtl/skid_pipeline_stage.sv
// One pipeline stage; MODE selects which handshake paths are registered.
// cnt reports how many beats this stage currently holds (0..2).
module skid_stage
    import skid_pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MODE       = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [STAGE_CNT_W-1:0] cnt
);

    localparam skid_mode_t M = skid_mode_t'(MODE);

    if (M == SKID_BYPASS) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign out_data  = in_data;
        assign out_valid = in_valid;
        assign in_ready  = out_ready;
        assign cnt       = '0;
    end else if (M == SKID_FWD) begin : g_fwd
        logic [DATA_WIDTH-1:0] data_q, data_d;
        logic                  valid_q, valid_d;

        always_comb begin
            in_ready = !valid_q || out_ready;
            data_d   = data_q;
            valid_d  = valid_q;
            if (in_valid && in_ready) begin
                data_d  = in_data;
                valid_d = 1'b1;
            end else if (out_ready) begin
                valid_d = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                data_q  <= data_d;
                valid_q <= valid_d;
            end
        end

        assign out_data  = data_q;
        assign out_valid = valid_q;
        assign cnt       = {1'b0, valid_q};
    end else if (M == SKID_BWD) begin : g_bwd
        logic [DATA_WIDTH-1:0] skid_q, skid_d;
        logic                  skid_valid_q, skid_valid_d;

        // Input passes straight through while the skid is empty; a stalled
        // accepted beat parks in the skid and upstream sees ready drop next cycle.
        always_comb begin
            in_ready     = !skid_valid_q;
            out_valid    = skid_valid_q || in_valid;
            out_data     = skid_valid_q ? skid_q : in_data;
            skid_d       = skid_q;
            skid_valid_d = skid_valid_q;
            if (skid_valid_q) begin
                if (out_ready) skid_valid_d = 1'b0;
            end else if (in_valid && !out_ready) begin
                skid_d       = in_data;
                skid_valid_d = 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                skid_q       <= '0;
                skid_valid_q <= 1'b0;
            end else begin
                skid_q       <= skid_d;
                skid_valid_q <= skid_valid_d;
            end
        end

        assign cnt = {1'b0, skid_valid_q};
    end else begin : g_full
        skid_state_t           state_q, state_d;
        logic [DATA_WIDTH-1:0] main_q, main_d, skid_q, skid_d;
        logic                  in_ready_q, in_ready_d;
        logic                  out_valid_q, out_valid_d;
        logic                  in_acc, out_acc;

        always_comb begin
            in_acc  = in_valid && in_ready_q;
            out_acc = out_valid_q && out_ready;
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;
            unique case (state_q)
                ST_EMPTY: if (in_acc) begin
                    state_d = ST_BUSY;
                    main_d  = in_data;
                end
                ST_BUSY: begin
                    if (in_acc && out_acc) begin
                        main_d = in_data;
                    end else if (in_acc) begin
                        state_d = ST_FULL;
                        skid_d  = in_data;
                    end else if (out_acc) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: if (out_acc) begin
                    state_d = ST_BUSY;
                    main_d  = skid_q;
                end
                default: state_d = ST_EMPTY;
            endcase
            // Both handshake outputs come from flops, derived from the next state.
            in_ready_d  = (state_d != ST_FULL);
            out_valid_d = (state_d != ST_EMPTY);
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q     <= ST_EMPTY;
                main_q      <= '0;
                skid_q      <= '0;
                in_ready_q  <= 1'b1;
                out_valid_q <= 1'b0;
            end else begin
                state_q     <= state_d;
                main_q      <= main_d;
                skid_q      <= skid_d;
                in_ready_q  <= in_ready_d;
                out_valid_q <= out_valid_d;
            end
        end

        assign in_ready  = in_ready_q;
        assign out_valid = out_valid_q;
        assign out_data  = main_q;
        assign cnt       = {state_q == ST_FULL, state_q == ST_BUSY};
    end

endmodule

// File: rtl/skid_pipeline.sv
// Chain of STAGES skid_stage instances between the upstream and downstream handshakes;
// occupancy is the sum of the per-stage held-beat counts.
module skid_pipeline
    import skid_pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 1,
    parameter int MODE       = 3,
    parameter int OCC_W      = $clog2(2*STAGES+1)
) (
    input  logic           clk,
    input  logic           rst,
    skid_pipeline_if.slave bus
);

    logic [STAGES-1:0][STAGE_CNT_W-1:0] cnt_w;
    logic [OCC_W-1:0]                   occ_sum;

    // Each stage owns its link wires so the ready chain stays a set of distinct nets.
    for (genvar i = 0; i < STAGES; i++) begin : g_st
        logic [DATA_WIDTH-1:0] d_in, d_out;
        logic                  v_in, v_out, r_in, r_out;

        if (i == 0) begin : g_first
            assign d_in         = bus.in_data;
            assign v_in         = bus.in_valid;
            assign bus.in_ready = r_in;
        end else begin : g_mid
            assign d_in = g_st[i-1].d_out;
            assign v_in = g_st[i-1].v_out;
        end

        if (i == STAGES-1) begin : g_last
            assign r_out         = bus.out_ready;
            assign bus.out_data  = d_out;
            assign bus.out_valid = v_out;
        end else begin : g_link
            assign r_out = g_st[i+1].r_in;
        end

        skid_stage #(.DATA_WIDTH(DATA_WIDTH), .MODE(MODE)) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_data   (d_in),
            .in_valid  (v_in),
            .in_ready  (r_in),
            .out_data  (d_out),
            .out_valid (v_out),
            .out_ready (r_out),
            .cnt       (cnt_w[i])
        );
    end

    always_comb begin
        occ_sum = '0;
        for (int i = 0; i < STAGES; i++) occ_sum = occ_sum + OCC_W'(cnt_w[i]);
    end

    assign bus.occupancy = occ_sum;

endmodule
